// File: rtl/sincos_lut_arbiter.sv
// sincos_lut_arbiter
// Round-robin arbiter that shares a single sin/cos LUT read port (2-cycle
// read latency) between N_REQ requesters. A cos request is turned into a
// sin lookup by adding a quarter period to the angle. A 3-stage tag
// pipeline carries the requester id alongside the LUT latency so each
// result returns to the requester that asked for it.
//
// Optional build macro: SINCOS_ARB_STATS_EN
//   Adds stall_count and lookup_count (32-bit, saturating). stall_count
//   advances by the number of requesters that are valid but not granted in
//   a cycle, so two stalled requesters in one cycle add two.
module sincos_lut_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ENTRIES = 1024,
  localparam int ADDR_W = $clog2(ENTRIES),
  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_angle,
  input  logic [N_REQ-1:0]          req_cos,
  output logic [N_REQ-1:0]          req_ready,
  output logic [ADDR_W-1:0]         lut_addr,
  input  logic [15:0]               lut_data,
  output logic [N_REQ-1:0]          resp_valid,
  output logic [15:0]               resp_val
`ifdef SINCOS_ARB_STATS_EN
  ,
  output logic [31:0]               stall_count,
  output logic [31:0]               lookup_count
`endif
);

  localparam logic [ADDR_W-1:0] QUARTER   = ADDR_W'(ENTRIES / 4);
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0]  rr_ptr;
  logic [N_REQ-1:0]  busy;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;
  int                scan_idx;

  logic              s0_valid, s1_valid, s2_valid;
  logic [PTR_W-1:0]  s0_id, s1_id, s2_id;

  logic [ADDR_W-1:0] sel_angle;
  logic [ADDR_W-1:0] next_addr;

  assign eligible = req_valid & ~busy;

  // Rotating-priority search: first eligible index at or above rr_ptr, wrapping.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = 0;
    for (int j = 0; j < N_REQ; j++) begin
      scan_idx = (int'(rr_ptr) + j) % N_REQ;
      if (!grant_any && eligible[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_idx       = PTR_W'(scan_idx);
        grant_any       = 1'b1;
      end
    end
  end

  // Grant is suppressed while reset is held so nothing looks accepted.
  assign req_ready = grant & {N_REQ{rst_in}};

  // Angle of the granted requester, with the quarter-period shift for cos.
  always_comb begin
    sel_angle = req_angle[grant_idx*ADDR_W +: ADDR_W];
    next_addr = sel_angle + (req_cos[grant_idx] ? QUARTER : '0);
  end

  // Address register, round-robin pointer and per-requester busy flags.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      lut_addr <= '0;
      rr_ptr   <= '0;
      busy     <= '0;
    end else begin
      busy <= (busy & ~resp_valid) | grant;
      if (grant_any) begin
        lut_addr <= next_addr;
        rr_ptr   <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Tag pipeline: s0 lines up with lut_addr, s2 with the LUT output.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s0_id    <= '0;
      s1_id    <= '0;
      s2_id    <= '0;
    end else begin
      s0_valid <= grant_any;
      s0_id    <= grant_idx;
      s1_valid <= s0_valid;
      s1_id    <= s0_id;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
    end
  end

  // Decode the returning tag into the one-hot response strobe.
  always_comb begin
    resp_valid = '0;
    if (s2_valid) resp_valid[s2_id] = 1'b1;
  end

  assign resp_val = lut_data;

`ifdef SINCOS_ARB_STATS_EN
  logic [N_REQ-1:0] stalled;
  logic [32:0]      stall_sum;

  assign stalled = req_valid & ~req_ready;

  // Sum this cycle's stalled requesters onto the running total.
  always_comb begin
    stall_sum = {1'b0, stall_count};
    for (int i = 0; i < N_REQ; i++) begin
      stall_sum = stall_sum + 33'(stalled[i]);
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stall_count  <= '0;
      lookup_count <= '0;
    end else begin
      stall_count <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
      if (grant_any && (lookup_count != 32'hFFFF_FFFF)) begin
        lookup_count <= lookup_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/sincos_lut_arbiter.md
Name: sincos_lut_arbiter

Overview:
- Shares one sin/cos lookup-table BRAM port (ENTRIES x 16-bit signed, one full period of sin, 2-cycle read latency) between N_REQ requesters, e.g. the rotation and projection units.
- Round-robin arbitration, one lookup accepted per cycle.
- Converts a cos request into a quarter-period address offset.
- Tags each lookup through the BRAM latency so the result returns to the correct requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ENTRIES, 1024, table depth; power of 2, at least 4. ADDR_W = $clog2(ENTRIES).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous assert, active-low
- req_valid  input  N_REQ  per-requester lookup request
- req_angle  input  N_REQ*ADDR_W  angle for requester i in bits [i*ADDR_W +: ADDR_W]
- req_cos  input  N_REQ  1 = cos lookup, 0 = sin lookup
- req_ready  output  N_REQ  one-hot grant; handshake when req_valid[i] && req_ready[i]
- lut_addr  output  ADDR_W  registered address to the LUT read port
- lut_data  input  16  signed LUT data, valid 2 cycles after lut_addr changes
- resp_valid  output  N_REQ  one-hot; result for requester i is present
- resp_val  output  16  signed result, shared by all requesters

Behaviour:
- Reset (rst_in low, asynchronous):
  - lut_addr = 0, rr_ptr = 0, busy = 0, tag pipeline cleared.
  - resp_valid = 0, req_ready = 0.
  - In-flight lookups are discarded; no response is ever issued for them.
- Eligibility: eligible[i] = req_valid[i] && !busy[i]. A requester has at most one lookup outstanding.
- Grant (combinational from eligible and rr_ptr):
  - Select the first eligible index at or above rr_ptr, wrapping modulo N_REQ.
  - req_ready is one-hot on that index; all zero if no index is eligible.
  - Requesters must not make req_valid depend on req_ready.
- On a handshake for requester g at edge E0:
  - lut_addr <= req_angle[g] + (req_cos[g] ? ENTRIES/4 : 0), truncated to ADDR_W bits. Wrap-around is intended: cos(x) = sin(x + pi/2).
  - rr_ptr <= (g + 1) mod N_REQ.
  - busy[g] <= 1.
  - Tag stage 0 <= {valid = 1, id = g}.
- With no handshake: lut_addr holds its value, rr_ptr is unchanged, tag stage 0 valid <= 0.
- Tag pipeline: 3 register stages (s0 -> s1 -> s2), aligned with the LUT's two internal registers.
- Response:
  - resp_valid = onehot(s2.id) when s2.valid, else 0.
  - resp_val = lut_data, combinational pass-through.
  - resp_val is don't-care when resp_valid = 0.
  - No backpressure: a requester must take the result in the cycle it is presented.
- Latency: handshake in cycle k -> resp_valid in cycle k+3. Throughput is 1 lookup/cycle across requesters.
- busy[i] clears on the edge that ends its response cycle. The earliest re-accept of requester i is cycle k+4. Same-cycle clear and set of one requester is not possible.
- Simultaneous requests: exactly one grant per cycle. Losers hold valid; the rotating priority guarantees each is served within N_REQ cycles of becoming eligible.
- Single eligible requester: granted immediately, regardless of rr_ptr.
- req_angle and req_cos are sampled only at the handshake edge.

Optional Feature:
- Macro: SINCOS_ARB_STATS_EN.
- When defined, two extra outputs are added:
  - stall_count (32-bit): increments each cycle in which any req_valid is high but that requester is not granted (busy, or lost arbitration).
  - lookup_count (32-bit): increments per handshake.
  - Both counters saturate at 2^32-1 and reset to 0 under rst_in.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single request: N_REQ=4, ENTRIES=1024. Requester 1 sin, angle 256, one cycle in cycle 5 -> lut_addr=256 from cycle 6; resp_valid=4'b0010 in cycle 8 with resp_val = table[256]; no other resp_valid.
- Cos wrap: requester 0 cos with angle 900 -> lut_addr=(900+256) mod 1024 = 132; response equals table[132].
- All four requesters held valid from reset release, rr_ptr=0 -> grants 0,1,2,3 in consecutive cycles; responses 3 cycles later each; next grant to 0 is not before its 4th cycle after its first handshake.
- Requester 2 held valid continuously alone -> handshakes every 4 cycles (busy gating); req_ready[2]=0 for the 3 cycles between.
- rst_in pulsed low one cycle after two handshakes -> no resp_valid ever appears for them; rr_ptr=0 so requester 0 wins the next contention.
- With SINCOS_ARB_STATS_EN: requesters 0 and 3 valid for 10 cycles -> lookup_count matches handshake count; stall_count equals the summed valid-but-ungranted cycles computed by the scoreboard.
